// File: rtl/resonator_bank_if.sv
// Sample/coefficient/result bundle of the resonator bank.
// The master side feeds samples and coefficients; the slave side returns results.
interface resonator_bank_if #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 16,
    parameter int CH_W   = 2
);
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic                     sample_ready;
    logic                     clr_state;
    logic                     coef_wr_en;
    logic [CH_W-1:0]          coef_wr_addr;
    logic signed [COEF_W-1:0] coef_t1;
    logic signed [COEF_W-1:0] coef_t2;
    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;
    logic                     out_frame_end;

    modport master (
        output sample_in, sample_valid, clr_state, coef_wr_en, coef_wr_addr, coef_t1, coef_t2,
        input  sample_ready, out_valid, out_ch, out_data, out_last, out_frame_end
    );

    modport slave (
        input  sample_in, sample_valid, clr_state, coef_wr_en, coef_wr_addr, coef_t1, coef_t2,
        output sample_ready, out_valid, out_ch, out_data, out_last, out_frame_end
    );
endinterface

// File: rtl/resonator_bank.sv
// Time-multiplexed bank of second-order Goertzel-style resonators sharing one multiplier pair.
// Each accepted sample visits every channel, one per cycle, with frame-based state clearing.
module resonator_bank #(
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 16,
    parameter int NUM_CH    = 4,
    parameter int FRAME_LEN = 256,
    parameter int SHIFT     = 2,
    parameter int SATURATE  = 0
) (
    input  logic              clk_in,
    input  logic              rst_sys,
    resonator_bank_if.slave   bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {IDLE, PROC} state_t;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          k_q, k_d;
    logic signed [DATA_W-1:0] x_q, x_d;
    logic [FC_W-1:0]          frame_q, frame_d;
    logic signed [DATA_W-1:0] q1_q [NUM_CH];
    logic signed [DATA_W-1:0] q2_q [NUM_CH];
    logic signed [COEF_W-1:0] t1_q [NUM_CH];
    logic signed [COEF_W-1:0] t2_q [NUM_CH];

    logic                     outValid_q;
    logic [CH_W-1:0]          outCh_q;
    logic signed [DATA_W-1:0] outData_q;
    logic                     outLast_q;
    logic                     outFrameEnd_q;

    logic                     readyInt;
    logic                     lastCh;
    logic                     frameEnd;
    logic                     busy;
    logic signed [COEF_W-1:0] q1h;
    logic signed [DATA_W-1:0] q2Cur;
    logic signed [DATA_W-1:0] prod;
    logic signed [DATA_W-1:0] fb;
    logic signed [DATA_W+1:0] sum;
    logic                     ovf;
    logic signed [DATA_W-1:0] s;
    logic signed [COEF_W-1:0] sHi;
    logic signed [DATA_W-1:0] outProd;

    // Shared datapath for the channel selected by k_q; the sum keeps two guard bits.
    always_comb begin
        q1h     = q1_q[k_q][DATA_W-1 -: COEF_W];
        q2Cur   = q2_q[k_q];
        prod    = q1h * t1_q[k_q];
        fb      = prod <<< SHIFT;
        sum     = {{2{x_q[DATA_W-1]}}, x_q} + {{2{fb[DATA_W-1]}}, fb}
                - {{2{q2Cur[DATA_W-1]}}, q2Cur};
        ovf     = (sum[DATA_W+1:DATA_W-1] != 3'b000) && (sum[DATA_W+1:DATA_W-1] != 3'b111);
        s       = sum[DATA_W-1:0];
        if ((SATURATE != 0) && ovf) begin
            s = sum[DATA_W+1] ? SMIN : SMAX;
        end
        sHi     = s[DATA_W-1 -: COEF_W];
        outProd = sHi * t2_q[k_q];
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        x_d      = x_q;
        frame_d  = frame_q;
        readyInt = 1'b0;
        busy     = (state_q == PROC);
        lastCh   = (k_q == CH_W'(NUM_CH - 1));
        frameEnd = (frame_q == FC_W'(FRAME_LEN - 1));
        case (state_q)
            IDLE: begin
                readyInt = 1'b1;
                if (bus.sample_valid && !bus.clr_state) begin
                    state_d = PROC;
                    k_d     = '0;
                    x_d     = bus.sample_in;
                end
            end
            PROC: begin
                k_d = k_q + 1'b1;
                if (lastCh) begin
                    state_d = IDLE;
                    frame_d = frameEnd ? '0 : frame_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A soft clear abandons whatever is in flight, including a same-cycle handshake.
        if (bus.clr_state) begin
            state_d = IDLE;
            frame_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_sys) begin
            state_q       <= IDLE;
            k_q           <= '0;
            x_q           <= '0;
            frame_q       <= '0;
            outValid_q    <= 1'b0;
            outCh_q       <= '0;
            outData_q     <= '0;
            outLast_q     <= 1'b0;
            outFrameEnd_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                q1_q[i] <= '0;
                q2_q[i] <= '0;
                t1_q[i] <= '0;
                t2_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            x_q        <= x_d;
            frame_q    <= frame_d;
            outValid_q <= busy && !bus.clr_state;
            if (busy && !bus.clr_state) begin
                outCh_q       <= k_q;
                outData_q     <= outProd;
                outLast_q     <= lastCh;
                outFrameEnd_q <= frameEnd;
            end
            // The frame-end clear overrides the last channel's own state update.
            if (bus.clr_state || (busy && lastCh && frameEnd)) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    q1_q[i] <= '0;
                    q2_q[i] <= '0;
                end
            end else if (busy) begin
                q2_q[k_q] <= q1_q[k_q];
                q1_q[k_q] <= s;
            end
            if (bus.coef_wr_en && (int'(bus.coef_wr_addr) < NUM_CH)) begin
                t1_q[bus.coef_wr_addr] <= bus.coef_t1;
                t2_q[bus.coef_wr_addr] <= bus.coef_t2;
            end
        end
    end

    assign bus.sample_ready  = readyInt && !rst_sys;
    assign bus.out_valid     = outValid_q;
    assign bus.out_ch        = outCh_q;
    assign bus.out_data      = outData_q;
    assign bus.out_last      = outLast_q;
    assign bus.out_frame_end = outFrameEnd_q;
endmodule

// File: tb/tb_resonator_bank.sv
// Drives a wrapping (FRAME_LEN=4) and a saturating (FRAME_LEN=256) bank with identical stimulus
// and compares every result against an arithmetic reference model.
module tb_resonator_bank;
    logic        clk = 1'b0;
    logic        rstSys;
    logic [31:0] sampleIn;
    logic        sampleValid;
    logic        clrState;
    logic        coefWrEn;
    logic [1:0]  coefAddr;
    logic [15:0] coefT1;
    logic [15:0] coefT2;

    int testsRun = 0;
    int failCount = 0;

    resonator_bank_if #(.DATA_W(32), .COEF_W(16), .CH_W(2)) ifA ();
    resonator_bank_if #(.DATA_W(32), .COEF_W(16), .CH_W(2)) ifB ();

    resonator_bank #(.DATA_W(32), .COEF_W(16), .NUM_CH(4), .FRAME_LEN(4), .SHIFT(2), .SATURATE(0))
        dutA (.clk_in(clk), .rst_sys(rstSys), .bus(ifA.slave));
    resonator_bank #(.DATA_W(32), .COEF_W(16), .NUM_CH(4), .FRAME_LEN(256), .SHIFT(2), .SATURATE(1))
        dutB (.clk_in(clk), .rst_sys(rstSys), .bus(ifB.slave));

    assign ifA.sample_in = sampleIn;    assign ifB.sample_in = sampleIn;
    assign ifA.sample_valid = sampleValid; assign ifB.sample_valid = sampleValid;
    assign ifA.clr_state = clrState;    assign ifB.clr_state = clrState;
    assign ifA.coef_wr_en = coefWrEn;   assign ifB.coef_wr_en = coefWrEn;
    assign ifA.coef_wr_addr = coefAddr; assign ifB.coef_wr_addr = coefAddr;
    assign ifA.coef_t1 = coefT1;        assign ifB.coef_t1 = coefT1;
    assign ifA.coef_t2 = coefT2;        assign ifB.coef_t2 = coefT2;

    logic        rdy [2];
    logic        oValid [2];
    logic [1:0]  oCh [2];
    logic [31:0] oData [2];
    logic        oLast [2];
    logic        oFe [2];
    assign rdy[0] = ifA.sample_ready;   assign rdy[1] = ifB.sample_ready;
    assign oValid[0] = ifA.out_valid;   assign oValid[1] = ifB.out_valid;
    assign oCh[0] = ifA.out_ch;         assign oCh[1] = ifB.out_ch;
    assign oData[0] = ifA.out_data;     assign oData[1] = ifB.out_data;
    assign oLast[0] = ifA.out_last;     assign oLast[1] = ifB.out_last;
    assign oFe[0] = ifA.out_frame_end;  assign oFe[1] = ifB.out_frame_end;

    always #5 clk = ~clk;

    // Reference model: per-instance resonator states as plain integers.
    int     frameLen [2] = '{4, 256};
    int     satMode [2] = '{0, 1};
    longint mQ1 [2][4];
    longint mQ2 [2][4];
    longint mT1 [4];
    longint mT2 [4];
    int     mFrame [2];
    longint mOut [2][4];
    logic   mFe [2];
    longint lastData [2][4];
    logic   lastFe [2];

    function automatic longint wrap32(input longint v);
        return longint'(int'(v));
    endfunction

    function automatic void modelSample(input longint x);
        longint fb, sum, s;
        for (int d = 0; d < 2; d++) begin
            mFe[d] = (mFrame[d] == frameLen[d] - 1);
            for (int k = 0; k < 4; k++) begin
                fb  = wrap32((mQ1[d][k] >>> 16) * mT1[k] * 4);
                sum = x + fb - mQ2[d][k];
                if (satMode[d] != 0)
                    s = (sum > 64'sd2147483647) ? 64'sd2147483647 :
                        (sum < -64'sd2147483648) ? -64'sd2147483648 : sum;
                else
                    s = wrap32(sum);
                mOut[d][k] = wrap32((s >>> 16) * mT2[k]);
                mQ2[d][k] = mQ1[d][k];
                mQ1[d][k] = s;
            end
            if (mFe[d]) begin
                mFrame[d] = 0;
                for (int k = 0; k < 4; k++) begin mQ1[d][k] = 0; mQ2[d][k] = 0; end
            end else begin
                mFrame[d]++;
            end
        end
    endfunction

    function automatic void modelClear(input bit coefsToo);
        for (int d = 0; d < 2; d++) begin
            mFrame[d] = 0;
            for (int k = 0; k < 4; k++) begin mQ1[d][k] = 0; mQ2[d][k] = 0; end
        end
        if (coefsToo)
            for (int k = 0; k < 4; k++) begin mT1[k] = 0; mT2[k] = 0; end
    endfunction

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyCoef(input int ch, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        coefWrEn = 1'b1; coefAddr = 2'(ch); coefT1 = a; coefT2 = b;
        @(posedge clk); #1;
        coefWrEn = 1'b0;
        mT1[ch] = longint'($signed(a));
        mT2[ch] = longint'($signed(b));
    endtask

    task automatic applyClear();
        @(negedge clk);
        clrState = 1'b1;
        @(posedge clk); #1;
        clrState = 1'b0;
        modelClear(1'b0);
    endtask

    // One full sample; optionally rewrites channel midCh's coefficients during its own compute cycle.
    task automatic applyStimulus(input logic [31:0] x, input int midCh,
                                 input logic [15:0] wT1, input logic [15:0] wT2);
        int guard = 0;
        @(negedge clk);
        while (!(rdy[0] && rdy[1]) && guard < 50) begin @(negedge clk); guard++; end
        checkOutput("readyWait", longint'(guard < 50), 1);
        sampleIn = x; sampleValid = 1'b1;
        modelSample(longint'($signed(x)));
        @(posedge clk); #1;
        sampleValid = 1'b0;
        for (int d = 0; d < 2; d++) checkOutput($sformatf("busy%0d", d), longint'(rdy[d]), 0);
        for (int k = 0; k < 4; k++) begin
            if (k == midCh) begin
                coefWrEn = 1'b1; coefAddr = 2'(k); coefT1 = wT1; coefT2 = wT2;
            end
            @(posedge clk); #1;
            coefWrEn = 1'b0;
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("valid%0d_ch%0d", d, k), longint'(oValid[d]), 1);
                checkOutput($sformatf("ch%0d_ch%0d", d, k), longint'(oCh[d]), k);
                checkOutput($sformatf("last%0d_ch%0d", d, k), longint'(oLast[d]), longint'(k == 3));
                checkOutput($sformatf("fe%0d_ch%0d", d, k), longint'(oFe[d]), longint'(mFe[d]));
                checkOutput($sformatf("data%0d_ch%0d", d, k), longint'($signed(oData[d])), mOut[d][k]);
                lastData[d][k] = longint'($signed(oData[d]));
                lastFe[d] = oFe[d];
            end
        end
        if (midCh >= 0) begin
            mT1[midCh] = longint'($signed(wT1));
            mT2[midCh] = longint'($signed(wT2));
        end
        for (int d = 0; d < 2; d++) checkOutput($sformatf("readyBack%0d", d), longint'(rdy[d]), 1);
    endtask

    initial begin
        longint quarter [5] = '{1, 0, -1, 0, 1};
        longint sixth [7] = '{1, 1, 0, -1, -1, 0, 1};
        longint frameData [6] = '{1, 1, 0, -1, 0, 0};
        logic   frameFe [6] = '{0, 0, 0, 1, 0, 0};
        int     readyCount;

        rstSys = 1'b1; sampleIn = '0; sampleValid = 1'b0; clrState = 1'b0;
        coefWrEn = 1'b0; coefAddr = '0; coefT1 = '0; coefT2 = '0;
        modelClear(1'b1);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rstReady%0d", d), longint'(rdy[d]), 0);
            checkOutput($sformatf("rstValid%0d", d), longint'(oValid[d]), 0);
            checkOutput($sformatf("rstData%0d", d), longint'(oData[d]), 0);
        end
        @(negedge clk); rstSys = 1'b0; #1;
        checkOutput("relReady", longint'(rdy[0]), 1);

        // Sixth-rate resonance on ch0, silent channels elsewhere.
        applyCoef(0, 16'd16384, 16'd1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus((i == 0) ? 32'h0001_0000 : 32'h0, -1, '0, '0);
            checkOutput($sformatf("sixth%0d", i), lastData[1][0], sixth[i]);
            checkOutput($sformatf("sixthIdle%0d", i), lastData[1][3], 0);
        end

        // Overflow on the second sample: wrap versus clamp.
        applyClear();
        applyStimulus(32'h7FFF_0000, -1, '0, '0);
        applyStimulus(32'h7FFF_0000, -1, '0, '0);
        checkOutput("ovfWrap", lastData[0][0], -2);
        checkOutput("ovfSat", lastData[1][0], 32767);

        // Frame boundary on the FRAME_LEN=4 instance.
        applyClear();
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i == 0) ? 32'h0001_0000 : 32'h0, -1, '0, '0);
            checkOutput($sformatf("frameData%0d", i), lastData[0][0], frameData[i]);
            checkOutput($sformatf("frameFe%0d", i), longint'(lastFe[0]), longint'(frameFe[i]));
        end

        // Back-to-back handshakes with sample_valid held high.
        applyClear();
        readyCount = 0;
        @(negedge clk);
        sampleIn = '0; sampleValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rdy[0]) begin readyCount++; modelSample(0); end
            @(negedge clk);
        end
        sampleValid = 1'b0;
        checkOutput("readyPulses", readyCount, 4);
        repeat (6) @(negedge clk);

        // Coefficient write to ch2 during its own compute cycle lands on the next sample.
        applyClear();
        applyCoef(2, 16'd0, 16'd1);
        applyStimulus(32'h0001_0000, 2, 16'd0, 16'd3);
        checkOutput("midWriteOld", lastData[0][2], 1);
        applyStimulus(32'h0, -1, '0, '0);
        applyStimulus(32'h0, -1, '0, '0);
        checkOutput("midWriteNew", lastData[0][2], -3);

        // Randomised samples and coefficients.
        applyClear();
        for (int i = 0; i < 30; i++) begin
            if (i % 6 == 0)
                applyCoef($urandom_range(0, 3), 16'($urandom), 16'($urandom));
            applyStimulus($urandom, -1, '0, '0);
        end

        // Soft clear on the ch1 compute cycle, then quarter-rate resonance from scratch.
        applyClear();
        applyCoef(0, 16'd0, 16'd1);
        @(negedge clk);
        sampleIn = 32'h0001_0000; sampleValid = 1'b1;
        @(posedge clk); #1; sampleValid = 1'b0;
        @(posedge clk); #1;
        checkOutput("abortCh0", longint'(oValid[0]), 1);
        checkOutput("abortCh0Data", longint'($signed(oData[1])), 1);
        clrState = 1'b1;
        @(posedge clk); #1; clrState = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("clrValid%0d", d), longint'(oValid[d]), 0);
            checkOutput($sformatf("clrReady%0d", d), longint'(rdy[d]), 1);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("clrSilent%0d", i), longint'(oValid[0] | oValid[1]), 0);
        end
        modelClear(1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus((i == 0) ? 32'h0001_0000 : 32'h0, -1, '0, '0);
            checkOutput($sformatf("quarter%0d", i), lastData[1][0], quarter[i]);
        end

        // Reset in the middle of a sample also wipes the coefficients.
        @(negedge clk);
        sampleIn = 32'h0001_0000; sampleValid = 1'b1;
        @(posedge clk); #1; sampleValid = 1'b0;
        @(posedge clk); #1;
        rstSys = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("rstMidValid%0d", i), longint'(oValid[0] | oValid[1]), 0);
            checkOutput($sformatf("rstMidReady%0d", i), longint'(rdy[0] | rdy[1]), 0);
        end
        @(negedge clk); rstSys = 1'b0; #1;
        checkOutput("rstMidRelease", longint'(rdy[0] & rdy[1]), 1);
        modelClear(1'b1);
        applyStimulus(32'h0001_0000, -1, '0, '0);
        checkOutput("rstCoefZero", lastData[1][0], 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
